// File: rtl/perf_counter_pkg.sv
// Shared types and helpers for the transfer performance counter bank.
// Counter widths up to MAX_CNT_W bits are supported by the saturating increment.
package perf_counter_pkg;

   typedef enum logic {
      WAIT     = 1'b0,
      COUNTING = 1'b1
   } state_t;

   localparam int MAX_CNT_W = 128;

   // Increment that sticks at the all-ones value of a width-bit counter instead of wrapping.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                    input int unsigned width);
      logic [MAX_CNT_W-1:0] all_ones;
      if (width >= MAX_CNT_W) begin
         all_ones = '1;
      end else begin
         all_ones = (MAX_CNT_W'(1) << width) - MAX_CNT_W'(1);
      end
      return (value >= all_ones) ? value : value + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One transfer measurement channel: WAIT/COUNTING state machine plus
// saturating cycle, idle and beat counters with sticky saturation flag.
module perf_counter_channel
   import perf_counter_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             hs,
   input  logic             last,
   output logic [CNT_W-1:0] cycles,
   output logic [CNT_W-1:0] idle_cycles,
   output logic [CNT_W-1:0] beats,
   output logic             busy,
   output logic             done,
   output logic             saturated
);

   state_t state;
   state_t state_next;

   logic [CNT_W-1:0] cycles_next;
   logic [CNT_W-1:0] idle_next;
   logic [CNT_W-1:0] beats_next;
   logic             done_next;
   logic             sat_next;

   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] value);
      return CNT_W'(sat_inc(MAX_CNT_W'(value), CNT_W));
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state <= WAIT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         WAIT:     if (hs && !last) state_next = COUNTING;
         COUNTING: if (hs && last)  state_next = WAIT;
         default:  state_next = WAIT;
      endcase
   end

   // Counters hold in WAIT so the last transfer's results stay readable.
   always_comb begin
      cycles_next = cycles;
      idle_next   = idle_cycles;
      beats_next  = beats;
      sat_next    = saturated;
      done_next   = 1'b0;
      case (state)
         WAIT: begin
            if (hs) begin
               cycles_next = CNT_W'(1);
               beats_next  = CNT_W'(1);
               idle_next   = '0;
               sat_next    = 1'b0;
               done_next   = last;
            end
         end
         COUNTING: begin
            cycles_next = inc(cycles);
            if (hs) begin
               beats_next = inc(beats);
            end else begin
               idle_next = inc(idle_cycles);
            end
            sat_next  = saturated | (&cycles_next) | (&beats_next) | (&idle_next);
            done_next = hs && last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cycles      <= '0;
         idle_cycles <= '0;
         beats       <= '0;
         saturated   <= 1'b0;
         done        <= 1'b0;
      end else begin
         cycles      <= cycles_next;
         idle_cycles <= idle_next;
         beats       <= beats_next;
         saturated   <= sat_next;
         done        <= done_next;
      end
   end

   assign busy = (state == COUNTING);

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of N_CH independent transfer performance counters.
// Define PERF_CNT_SNAPSHOT_EN to add atomic snapshot shadow registers.
module perf_counter_bank
   import perf_counter_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [N_CH-1:0]       is_handshake,
   input  logic [N_CH-1:0]       is_last,
   output logic [N_CH*CNT_W-1:0] cycles,
   output logic [N_CH*CNT_W-1:0] idle_cycles,
   output logic [N_CH*CNT_W-1:0] beats,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH-1:0]       done,
   output logic [N_CH-1:0]       saturated
`ifdef PERF_CNT_SNAPSHOT_EN
   ,
   input  logic                  snapshot,
   output logic [N_CH*CNT_W-1:0] snap_cycles,
   output logic [N_CH*CNT_W-1:0] snap_idle_cycles,
   output logic [N_CH*CNT_W-1:0] snap_beats,
   output logic                  snap_valid
`endif
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      perf_counter_channel #(
         .CNT_W(CNT_W)
      ) u_channel (
         .clk         (clk),
         .rst_n       (rst_n),
         .clear       (clear),
         .hs          (is_handshake[g]),
         .last        (is_last[g]),
         .cycles      (cycles[g*CNT_W +: CNT_W]),
         .idle_cycles (idle_cycles[g*CNT_W +: CNT_W]),
         .beats       (beats[g*CNT_W +: CNT_W]),
         .busy        (busy[g]),
         .done        (done[g]),
         .saturated   (saturated[g])
      );
   end

`ifdef PERF_CNT_SNAPSHOT_EN
   // Shadows capture the registered live values, i.e. what is displayed during the snapshot cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         snap_cycles      <= '0;
         snap_idle_cycles <= '0;
         snap_beats       <= '0;
         snap_valid       <= 1'b0;
      end else if (snapshot) begin
         snap_cycles      <= cycles;
         snap_idle_cycles <= idle_cycles;
         snap_beats       <= beats;
         snap_valid       <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: a 4x64 bank driven from a vector table,
// plus a 1x4 bank for saturation; expectations flow through a scoreboard queue.
module tb_perf_counter_bank;
   import perf_counter_pkg::*;

   typedef struct {
      int          dut;
      logic [3:0]  hs;
      logic [3:0]  last;
      logic        clr;
      int          ch;
      logic [63:0] cyc;
      logic [63:0] idle;
      logic [63:0] beats;
      logic [3:0]  busy;
      logic [3:0]  done;
      logic [3:0]  sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  is_handshake = '0;
   logic [3:0]  is_last = '0;
   logic [255:0] cycles, idle_cycles, beats;
   logic [3:0]  busy, done, saturated;

   logic        s_clear = 1'b0;
   logic [0:0]  s_hs = '0;
   logic [0:0]  s_last = '0;
   logic [3:0]  s_cycles, s_idle, s_beats;
   logic [0:0]  s_busy, s_done, s_sat;

`ifdef PERF_CNT_SNAPSHOT_EN
   logic         snapshot = 1'b0;
   logic [255:0] snap_cycles, snap_idle_cycles, snap_beats;
   logic         snap_valid;
   logic         s_snapshot = 1'b0;
   logic [3:0]   s_snap_cycles, s_snap_idle, s_snap_beats;
   logic         s_snap_valid;
`endif

   int   vectors_applied = 0;
   int   miscompares = 0;
   vec_t vecs[$];
   vec_t expect_q[$];

   always #5 clk = ~clk;

   perf_counter_bank #(.N_CH(4), .CNT_W(64)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .clear            (clear),
      .is_handshake     (is_handshake),
      .is_last          (is_last),
      .cycles           (cycles),
      .idle_cycles      (idle_cycles),
      .beats            (beats),
      .busy             (busy),
      .done             (done),
      .saturated        (saturated)
`ifdef PERF_CNT_SNAPSHOT_EN
      ,
      .snapshot         (snapshot),
      .snap_cycles      (snap_cycles),
      .snap_idle_cycles (snap_idle_cycles),
      .snap_beats       (snap_beats),
      .snap_valid       (snap_valid)
`endif
   );

   perf_counter_bank #(.N_CH(1), .CNT_W(4)) u_small (
      .clk              (clk),
      .rst_n            (rst_n),
      .clear            (s_clear),
      .is_handshake     (s_hs),
      .is_last          (s_last),
      .cycles           (s_cycles),
      .idle_cycles      (s_idle),
      .beats            (s_beats),
      .busy             (s_busy),
      .done             (s_done),
      .saturated        (s_sat)
`ifdef PERF_CNT_SNAPSHOT_EN
      ,
      .snapshot         (s_snapshot),
      .snap_cycles      (s_snap_cycles),
      .snap_idle_cycles (s_snap_idle),
      .snap_beats       (s_snap_beats),
      .snap_valid       (s_snap_valid)
`endif
   );

   function automatic vec_t mk(int dut, logic [3:0] hs, logic [3:0] last, logic clr, int ch,
                               longint cyc, longint idle, longint bt,
                               logic [3:0] bsy, logic [3:0] dn, logic [3:0] st);
      vec_t v;
      v.dut = dut;  v.hs = hs;  v.last = last;  v.clr = clr;  v.ch = ch;
      v.cyc = 64'(cyc);  v.idle = 64'(idle);  v.beats = 64'(bt);
      v.busy = bsy;  v.done = dn;  v.sat = st;
      return v;
   endfunction

   task automatic check_output();
      vec_t        e;
      logic [63:0] a_cyc, a_idle, a_beats;
      logic [3:0]  a_busy, a_done, a_sat;
      vectors_applied++;
      if (expect_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard: actual empty queue, required one pending expectation");
         return;
      end
      e = expect_q.pop_front();
      if (e.dut == 0) begin
         a_cyc  = cycles[e.ch*64 +: 64];
         a_idle = idle_cycles[e.ch*64 +: 64];
         a_beats = beats[e.ch*64 +: 64];
         a_busy = busy;  a_done = done;  a_sat = saturated;
      end else begin
         a_cyc  = 64'(s_cycles);
         a_idle = 64'(s_idle);
         a_beats = 64'(s_beats);
         a_busy = {3'b000, s_busy};  a_done = {3'b000, s_done};  a_sat = {3'b000, s_sat};
      end
      if (a_cyc !== e.cyc || a_idle !== e.idle || a_beats !== e.beats ||
          a_busy !== e.busy || a_done !== e.done || a_sat !== e.sat) begin
         miscompares++;
         $display("[TB] FAIL vec%0d dut%0d ch%0d: actual cyc=%0d idle=%0d beats=%0d busy=%b done=%b sat=%b, required cyc=%0d idle=%0d beats=%0d busy=%b done=%b sat=%b",
                  vectors_applied, e.dut, e.ch, a_cyc, a_idle, a_beats, a_busy, a_done, a_sat,
                  e.cyc, e.idle, e.beats, e.busy, e.done, e.sat);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      if (v.dut == 0) begin
         is_handshake = v.hs;  is_last = v.last;  clear = v.clr;
         s_hs = '0;  s_last = '0;  s_clear = 1'b0;
      end else begin
         s_hs = v.hs[0:0];  s_last = v.last[0:0];  s_clear = v.clr;
         is_handshake = '0;  is_last = '0;  clear = 1'b0;
      end
      expect_q.push_back(v);
      @(posedge clk);
      #1;
      check_output();
   endtask

`ifdef PERF_CNT_SNAPSHOT_EN
   task automatic check_snap(input string name, input longint e_cyc, input longint e_idle,
                             input longint e_beats, input logic e_valid);
      vectors_applied++;
      if (snap_cycles[63:0] !== 64'(e_cyc) || snap_idle_cycles[63:0] !== 64'(e_idle) ||
          snap_beats[63:0] !== 64'(e_beats) || snap_valid !== e_valid) begin
         miscompares++;
         $display("[TB] FAIL %s: actual snap cyc=%0d idle=%0d beats=%0d valid=%b, required cyc=%0d idle=%0d beats=%0d valid=%b",
                  name, snap_cycles[63:0], snap_idle_cycles[63:0], snap_beats[63:0], snap_valid,
                  e_cyc, e_idle, e_beats, e_valid);
      end
   endtask
`endif

   initial begin
      // Reset state, then ch0 single-beat transfer.
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 0, 0, 1, 0, 1, 4'b0000, 4'b0001, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 1, 4'b0000, 4'b0000, 4'b0000));
      // ch1 pattern 1,0,0,1,1(last); a stray last without handshake is ignored.
      vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 1, 1, 0, 1, 4'b0010, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 2, 1, 1, 4'b0010, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0010, 0, 1, 3, 2, 1, 4'b0010, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0010, 4'b0000, 0, 1, 4, 2, 2, 4'b0010, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0010, 4'b0010, 0, 1, 5, 2, 3, 4'b0000, 4'b0010, 4'b0000));
      for (int i = 0; i < 10; i++) begin
         vecs.push_back(mk(0, 4'b0000, (i == 3) ? 4'b1111 : 4'b0000, 0, 1, 5, 2, 3,
                           4'b0000, 4'b0000, 4'b0000));
      end
      // ch2 stays busy with last but no handshake; ch2 and ch3 complete together.
      vecs.push_back(mk(0, 4'b0100, 4'b0000, 0, 2, 1, 0, 1, 4'b0100, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0100, 0, 2, 2, 1, 1, 4'b0100, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0100, 0, 2, 3, 2, 1, 4'b0100, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b1000, 4'b0000, 0, 3, 1, 0, 1, 4'b1100, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b1100, 4'b1100, 0, 2, 5, 3, 2, 4'b0000, 4'b1100, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 3, 2, 0, 2, 4'b0000, 4'b0000, 4'b0000));
      // clear with a simultaneous final beat on ch0 wipes everything, no done.
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 2, 1, 1, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk(0, 4'b0001, 4'b0001, 0, 0, 2, 0, 2, 4'b0000, 4'b0001, 4'b0000));

      $display("[TB] starting perf_counter_bank bench");
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) apply_stimulus(vecs[i]);

      // Reset in mid-transfer aborts without a done pulse.
      apply_stimulus(mk(0, 4'b0010, 4'b0000, 0, 1, 1, 0, 1, 4'b0010, 4'b0000, 4'b0000));
      rst_n = 1'b0;
      apply_stimulus(mk(0, 4'b0010, 4'b0010, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
      rst_n = 1'b1;
      apply_stimulus(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));

      // 4-bit counters: cycles and idle stick at 15 during a long transfer.
      apply_stimulus(mk(1, 4'b0001, 4'b0000, 0, 0, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000));
      for (int k = 2; k <= 20; k++) begin
         apply_stimulus(mk(1, 4'b0000, 4'b0000, 0, 0, (k > 15) ? 15 : k,
                           (k - 1 > 15) ? 15 : k - 1, 1, 4'b0001, 4'b0000,
                           (k >= 15) ? 4'b0001 : 4'b0000));
      end
      apply_stimulus(mk(1, 4'b0001, 4'b0001, 0, 0, 15, 15, 2, 4'b0000, 4'b0001, 4'b0001));
      apply_stimulus(mk(1, 4'b0000, 4'b0000, 0, 0, 15, 15, 2, 4'b0000, 4'b0000, 4'b0001));
      apply_stimulus(mk(1, 4'b0001, 4'b0000, 0, 0, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000));
      apply_stimulus(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));

`ifdef PERF_CNT_SNAPSHOT_EN
      // Snapshot captures ch0 at cycles=7 while the live count moves on.
      apply_stimulus(mk(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 1, 4'b0001, 4'b0000, 4'b0000));
      for (int k = 2; k <= 7; k++) begin
         apply_stimulus(mk(0, 4'b0000, 4'b0000, 0, 0, k, k - 1, 1, 4'b0001, 4'b0000, 4'b0000));
      end
      snapshot = 1'b1;
      apply_stimulus(mk(0, 4'b0000, 4'b0000, 0, 0, 8, 7, 1, 4'b0001, 4'b0000, 4'b0000));
      snapshot = 1'b0;
      check_snap("snap_capture", 7, 6, 1, 1'b1);
      apply_stimulus(mk(0, 4'b0000, 4'b0000, 0, 0, 9, 8, 1, 4'b0001, 4'b0000, 4'b0000));
      check_snap("snap_hold", 7, 6, 1, 1'b1);
      snapshot = 1'b1;
      apply_stimulus(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
      snapshot = 1'b0;
      check_snap("snap_clear", 0, 0, 0, 1'b0);
`endif

      if (expect_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: actual %0d pending, required 0", expect_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Bank of N_CH independent transfer performance counters for stream interfaces in the datapath.
- Each channel measures one transfer: from its first handshake to the handshake carrying last.
- Per channel, it reports:
  - total cycles;
  - idle (non-handshake) cycles;
  - beat count;
  - a sticky saturation flag;
  - a one-cycle completion pulse.
- Results hold until the next transfer starts on that channel, so software or a CSR block can read them.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- CNT_W, 64, width of each counter (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous clear of all channels
- is_handshake  in  N_CH  per-channel valid&ready of the monitored stream
- is_last  in  N_CH  per-channel last flag; only meaningful when is_handshake is high
- cycles  out  N_CH x CNT_W  per-channel total cycles of the current or last transfer
- idle_cycles  out  N_CH x CNT_W  per-channel cycles inside the transfer with no handshake
- beats  out  N_CH x CNT_W  per-channel handshake count
- busy  out  N_CH  channel is in COUNTING
- done  out  N_CH  one-cycle pulse when a transfer completes
- saturated  out  N_CH  sticky: some counter of this channel hit all-ones during the current or last transfer

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all channels go to WAIT;
  - all counters become 0;
  - busy, done and saturated become 0.
  - Reset mid-transfer simply aborts the transfer; no done pulse.
- All outputs are registered. Effects of the inputs in cycle t are visible after edge t.
- Per-channel state machine, states WAIT and COUNTING:
  - WAIT, is_handshake=1:
    - cycles=1, beats=1, idle_cycles=0, saturated=0.
    - If is_last=1: stay in WAIT and pulse done.
    - Otherwise: go to COUNTING.
  - WAIT, is_handshake=0: hold all values. is_last is ignored.
  - COUNTING, every cycle: cycles+1.
  - COUNTING, is_handshake=1: beats+1.
  - COUNTING, is_handshake=0: idle_cycles+1.
  - COUNTING, is_handshake=1 and is_last=1: go to WAIT and pulse done. That final cycle is counted.
  - COUNTING, is_last=1 without is_handshake: ignored, no transition.
- Invariant in COUNTING and after done: cycles == beats + idle_cycles (absent saturation).
- done:
  - high for exactly the cycle after the final beat;
  - the counters show their final values in that same cycle;
  - busy is 0 in that cycle.
- Saturation:
  - each counter stops at 2^CNT_W-1 and never wraps;
  - saturated is set when any of the channel's counters reaches all-ones;
  - saturated clears only on a new transfer start, on clear, or on reset.
- clear=1:
  - same effect as reset on all channels (WAIT, counters 0, flags 0);
  - overrides any simultaneous handshake or last in that cycle, which is lost.
- Channels are fully independent. Simultaneous completions give simultaneous done pulses.

Optional Feature:
- PERF_CNT_SNAPSHOT_EN defined:
  - adds input snapshot (1) and outputs snap_cycles, snap_idle_cycles, snap_beats (each N_CH x CNT_W) and snap_valid (1);
  - on snapshot=1, every channel's live counter values at that edge are copied atomically into the shadow registers, and snap_valid is set;
  - snap values are exactly the values the live outputs display during the snapshot cycle, i.e. before that cycle's update;
  - shadows and snap_valid are zeroed by reset and by clear; clear wins over a simultaneous snapshot.
- PERF_CNT_SNAPSHOT_EN undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package perf_counter_pkg:
  - state_t enum (WAIT, COUNTING);
  - the saturating-increment function for CNT_W-wide values.
- Sub-module perf_counter_channel:
  - one state machine and three counters per channel;
  - instantiated N_CH times via generate.
- The bank top holds clear fan-out and the optional snapshot shadows.

Test Plan:
- ch0: single beat hs=1, last=1 from WAIT -> next cycle cycles=1, beats=1, idle=0, done[0]=1 for 1 cycle, busy[0]=0.
- ch1: hs pattern 1,0,0,1,1(last) -> after final edge cycles=5, beats=3, idle=2, done[1] pulses once; values hold for 10 further idle cycles.
- ch2: last=1 while hs=0 in COUNTING -> no transition, busy stays 1, idle increments.
- CNT_W=4: 20-cycle transfer -> cycles sticks at 15, saturated=1; a new transfer start resets saturated=0 and cycles=1.
- clear asserted together with hs on ch0 mid-transfer -> all channels 0, busy=0, no done pulse; the next hs starts a fresh count at 1.
- SNAPSHOT_EN: snapshot while ch0 is at cycles=7 -> snap_cycles[0]=7, snap_valid=1; live counter continues to 8, 9 while the snapshot holds 7.
